i2c_txn_arbiter: RTL and testbench

- Shares one i2c_master between NREQ requesters (e.g. sensor poller, config loader).
- Round-robin arbitration; latches the winner's descriptor (addr, rw, byte count) and starts the master.
- Routes the master's tx-pop and rx-write strobes to the granted requester, then reports completion or timeout.

---
 rtl/i2c_txn_arbiter.sv | 109 ++++++++++
 tb/tb_i2c_txn_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: round-robin sharing of one i2c master among NREQ requesters
module i2c_txn_arbiter #(
  parameter int NREQ = 2,
  parameter int TIMEOUT_CYC = 200000,
  parameter int TW = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [4*NREQ-1:0] req_len,
  input  logic [8*NREQ-1:0] tx_data,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   tx_pop,
  output logic [7:0]        rx_data,
  output logic [NREQ-1:0]   rx_vld,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [3:0]        m_cnt,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  input  logic              m_txff_rd,
  input  logic              m_rxff_wr,
  input  logic              m_done
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, START, RUN, CPL} state_t;
  state_t st, nxt;
  logic [IW-1:0] ptr, g, win;
  logic [IW:0] idx;
  logic found, h_tx, h_rx, h_done, ev_tx, ev_rx, ev_done, any_ev, in_run, to_hit, to_r;
  logic [TW-1:0] tcnt;
  assign ev_tx = m_txff_rd & ~h_tx;
  assign ev_rx = m_rxff_wr & ~h_rx;
  assign ev_done = m_done & ~h_done;
  assign any_ev = ev_tx | ev_rx | ev_done;
  assign in_run = st == RUN;
  assign to_hit = in_run && !any_ev && tcnt == TW'(TIMEOUT_CYC - 1);
  assign busy = st != IDLE;
  assign m_start = st == START;
  assign done = st == CPL ? gnt : '0;
  assign err = st == CPL && to_r ? gnt : '0;
  assign m_wdata = |gnt ? tx_data[8*g +: 8] : '0;
  // first requester at or after the pointer, wrapping
  always_comb begin
    win = ptr;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + (IW+1)'(i);
      idx = idx >= (IW+1)'(NREQ) ? idx - (IW+1)'(NREQ) : idx;
      if (!found && req[idx[IW-1:0]]) begin
        win = idx[IW-1:0];
        found = 1'b1;
      end
    end
  end
  always_comb begin
    nxt = st == IDLE ? (|req ? START : IDLE) :
          st == START ? RUN :
          st == RUN ? (ev_done || to_hit ? CPL : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      ptr <= '0;
      g <= '0;
      gnt <= '0;
      tx_pop <= '0;
      rx_vld <= '0;
      rx_data <= '0;
      m_addr <= '0;
      m_rw <= 1'b0;
      m_cnt <= '0;
      h_tx <= 1'b0;
      h_rx <= 1'b0;
      h_done <= 1'b0;
      tcnt <= '0;
      to_r <= 1'b0;
    end else begin
      st <= nxt;
      h_tx <= m_txff_rd;
      h_rx <= m_rxff_wr;
      h_done <= m_done;
      tx_pop <= in_run && ev_tx ? gnt : '0;
      rx_vld <= in_run && ev_rx ? gnt : '0;
      if (in_run && ev_rx) rx_data <= m_rdata;
      tcnt <= in_run && !any_ev ? tcnt + 1'b1 : '0;
      if (in_run) to_r <= to_hit;
      if (st == IDLE && |req) begin
        gnt <= NREQ'(1) << win;
        g <= win;
        m_addr <= req_addr[7*win +: 7];
        m_rw <= req_rw[win];
        m_cnt <= req_len[4*win +: 4];
        to_r <= 1'b0;
      end
      if (st == CPL) begin
        gnt <= '0;
        ptr <= g == IW'(NREQ - 1) ? '0 : g + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: directed tests of arbitration, routing, timeout and reset
module tb_i2c_txn_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req = '0;
  logic [13:0] req_addr = '0;
  logic [1:0] req_rw = '0;
  logic [7:0] req_len = '0;
  logic [15:0] tx_data = '0;
  logic [1:0] gnt, tx_pop, rx_vld, done, err;
  logic [7:0] rx_data, m_wdata;
  logic busy, m_start, m_rw;
  logic [6:0] m_addr;
  logic [3:0] m_cnt;
  logic [7:0] m_rdata = '0;
  logic m_txff_rd = 1'b0, m_rxff_wr = 1'b0, m_done = 1'b0;
  int passed = 0, total = 0;
  int cyc = 0, t_done = -1, n_start = 0, n_pop0 = 0, n_pop1 = 0, n_rx0 = 0, n_done = 0;
  logic [1:0] done_seen = '0, err_seen = '0;
  logic [7:0] rxq1[$];

  i2c_txn_arbiter #(.NREQ(2), .TIMEOUT_CYC(100), .TW(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_len(req_len), .tx_data(tx_data), .gnt(gnt), .tx_pop(tx_pop),
    .rx_data(rx_data), .rx_vld(rx_vld), .done(done), .err(err), .busy(busy),
    .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw), .m_cnt(m_cnt),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_txff_rd(m_txff_rd),
    .m_rxff_wr(m_rxff_wr), .m_done(m_done)
  );

  always #5 clk = ~clk;

  task automatic clear;
    t_done = -1; n_start = 0; n_pop0 = 0; n_pop1 = 0; n_rx0 = 0; n_done = 0;
    done_seen = '0; err_seen = '0; rxq1.delete();
  endtask

  task automatic tick;
    @(negedge clk);
    cyc++;
    n_start += int'(m_start);
    n_pop0 += int'(tx_pop[0]);
    n_pop1 += int'(tx_pop[1]);
    n_rx0 += int'(rx_vld[0]);
    if (rx_vld[1]) rxq1.push_back(rx_data);
    if (done != 0) begin
      n_done++;
      done_seen |= done;
      if (t_done < 0) t_done = cyc;
    end
    err_seen |= err;
  endtask

  task automatic set_m(input int which, input logic v);
    if (which == 0) m_txff_rd = v;
    else if (which == 1) m_rxff_wr = v;
    else m_done = v;
  endtask

  // master strobe held two cycles, then low two cycles
  task automatic strobe(input int which);
    tick; set_m(which, 1'b1); tick; tick; set_m(which, 1'b0); tick;
  endtask

  task automatic wait_gnt(output int c0);
    c0 = -1;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (gnt != 0) begin
        c0 = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; tick; tick;
    total++; if (gnt !== 2'b00) $display("FAIL rst_gnt got %b want 00", gnt); else passed++;
    total++; if ({busy, m_start, done, err, tx_pop, rx_vld} !== 10'd0) $display("FAIL rst_ctl got %b want 0", {busy, m_start, done, err, tx_pop, rx_vld}); else passed++;
    total++; if ({m_addr, m_rw, m_cnt, rx_data, m_wdata} !== 28'd0) $display("FAIL rst_data got %h want 0", {m_addr, m_rw, m_cnt, rx_data, m_wdata}); else passed++;
    rst = 1'b1; tick;
  endtask

  task automatic test_single_write;
    int c0;
    clear;
    req_addr[6:0] = 7'h50; req_rw[0] = 1'b0; req_len[3:0] = 4'd2; tx_data[7:0] = 8'h11;
    req = 2'b01;
    wait_gnt(c0);
    req = 2'b00;
    total++; if (gnt !== 2'b01) $display("FAIL wr_gnt got %b want 01", gnt); else passed++;
    total++; if ({m_addr, m_rw, m_cnt} !== {7'h50, 1'b0, 4'd2}) $display("FAIL wr_desc got %h want %h", {m_addr, m_rw, m_cnt}, {7'h50, 1'b0, 4'd2}); else passed++;
    total++; if (m_wdata !== 8'h11) $display("FAIL wr_wdata got %h want 11", m_wdata); else passed++;
    repeat (3) strobe(0);
    strobe(2);
    tick; tick;
    total++; if (n_start !== 1) $display("FAIL wr_start got %0d want 1", n_start); else passed++;
    total++; if (n_pop0 !== 3 || n_pop1 !== 0) $display("FAIL wr_pops got %0d/%0d want 3/0", n_pop0, n_pop1); else passed++;
    total++; if (n_done !== 1 || done_seen !== 2'b01 || err_seen !== 2'b00) $display("FAIL wr_done got %0d %b %b want 1 01 00", n_done, done_seen, err_seen); else passed++;
    total++; if (busy !== 1'b0 || gnt !== 2'b00) $display("FAIL wr_idle got %b %b want 0 00", busy, gnt); else passed++;
  endtask

  task automatic test_read_routing;
    int c0;
    clear;
    req_addr[13:7] = 7'h1D; req_rw[1] = 1'b1; req_len[7:4] = 4'd2;
    req = 2'b10;
    wait_gnt(c0);
    req = 2'b00;
    total++; if (gnt !== 2'b10 || m_addr !== 7'h1D || m_rw !== 1'b1) $display("FAIL rd_gnt got %b %h %b want 10 1d 1", gnt, m_addr, m_rw); else passed++;
    m_rdata = 8'hA5; strobe(1);
    m_rdata = 8'h3C; strobe(1);
    strobe(2);
    tick; tick;
    total++; if (rxq1.size() !== 2) $display("FAIL rd_cnt got %0d want 2", rxq1.size()); else passed++;
    total++; if (rxq1.size() != 2 || rxq1[0] !== 8'hA5 || rxq1[1] !== 8'h3C) $display("FAIL rd_data got %p want A5 3C", rxq1); else passed++;
    total++; if (n_rx0 !== 0) $display("FAIL rd_rx0 got %0d want 0", n_rx0); else passed++;
    total++; if (done_seen !== 2'b10 || err_seen !== 2'b00) $display("FAIL rd_done got %b %b want 10 00", done_seen, err_seen); else passed++;
  endtask

  task automatic test_round_robin;
    int c0;
    logic [1:0] order[4];
    rst = 1'b0; tick; rst = 1'b1;
    clear;
    tx_data[15:8] = 8'h22;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(c0);
      order[i] = gnt;
      if (i == 1) begin
        total++; if (m_wdata !== 8'h22) $display("FAIL rr_wdata got %h want 22", m_wdata); else passed++;
      end
      if (i == 3) req = 2'b00;
      strobe(2);
    end
    tick; tick;
    total++; if (order[0] !== 2'b01) $display("FAIL rr_g0 got %b want 01", order[0]); else passed++;
    total++; if (order[1] !== 2'b10) $display("FAIL rr_g1 got %b want 10", order[1]); else passed++;
    total++; if (order[2] !== 2'b01) $display("FAIL rr_g2 got %b want 01", order[2]); else passed++;
    total++; if (order[3] !== 2'b10) $display("FAIL rr_g3 got %b want 10", order[3]); else passed++;
    total++; if (n_done !== 4 || n_start !== 4) $display("FAIL rr_cnt got %0d %0d want 4 4", n_done, n_start); else passed++;
  endtask

  task automatic test_timeout;
    int c0;
    clear;
    req = 2'b01;
    wait_gnt(c0);
    req = 2'b00;
    for (int i = 0; i < 150 && t_done < 0; i++) tick;
    total++; if (t_done !== c0 + 101) $display("FAIL to_time got %0d want %0d", t_done - c0, 101); else passed++;
    total++; if (done_seen !== 2'b01 || err_seen !== 2'b01) $display("FAIL to_err got %b %b want 01 01", done_seen, err_seen); else passed++;
    tick; tick;
    total++; if (busy !== 1'b0 || n_done !== 1) $display("FAIL to_idle got %b %0d want 0 1", busy, n_done); else passed++;
  endtask

  task automatic test_watchdog;
    int c0;
    clear;
    req = 2'b01;
    wait_gnt(c0);
    req = 2'b00;
    for (int k = 0; k < 5; k++) begin
      repeat (88) tick;
      m_txff_rd = 1'b1; tick; tick; m_txff_rd = 1'b0;
    end
    total++; if (t_done !== -1) $display("FAIL wd_early got %0d want -1", t_done); else passed++;
    m_done = 1'b1; tick; tick; m_done = 1'b0; tick; tick;
    total++; if (t_done !== c0 + 451) $display("FAIL wd_time got %0d want %0d", t_done - c0, 451); else passed++;
    total++; if (done_seen !== 2'b01 || err_seen !== 2'b00 || n_pop0 !== 5) $display("FAIL wd_clean got %b %b %0d want 01 00 5", done_seen, err_seen, n_pop0); else passed++;
  endtask

  task automatic test_async_reset;
    int c0;
    clear;
    req = 2'b01;
    wait_gnt(c0);
    req = 2'b00;
    tick; tick;
    m_txff_rd = 1'b1; tick;
    #2 rst = 1'b0;
    #1;
    total++; if (gnt !== 2'b00 || busy !== 1'b0 || m_start !== 1'b0) $display("FAIL ar_ctl got %b %b %b want 00 0 0", gnt, busy, m_start); else passed++;
    total++; if ({tx_pop, rx_vld, done, err} !== 8'd0) $display("FAIL ar_pulse got %b want 0", {tx_pop, rx_vld, done, err}); else passed++;
    total++; if ({m_addr, m_rw, m_cnt, rx_data, m_wdata} !== 28'd0) $display("FAIL ar_data got %h want 0", {m_addr, m_rw, m_cnt, rx_data, m_wdata}); else passed++;
    m_txff_rd = 1'b0;
    clear;
    tick; tick; tick;
    rst = 1'b1;
    req = 2'b10;
    wait_gnt(c0);
    req = 2'b00;
    total++; if (gnt !== 2'b10) $display("FAIL ar_gnt got %b want 10", gnt); else passed++;
    total++; if (n_done !== 0 || n_pop0 !== 0) $display("FAIL ar_nodone got %0d %0d want 0 0", n_done, n_pop0); else passed++;
    strobe(2);
    tick;
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_read_routing;
    test_round_robin;
    test_timeout;
    test_watchdog;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
